// File: rtl/clock_ctrl_if.sv
// clock_ctrl_if: groups the button inputs and control outputs of clock_ctrl.
//   mode_btn_n, up_n, down_n : raw active-low push-buttons (asynchronous to clk)
//   mode                     : 00 RUN, 01 SET_SEC, 10 SET_MIN, 11 SET_HOUR
//   sec_en                   : one-cycle 1 Hz count enable (RUN only)
//   en_5hz                   : one-cycle setting step enable (set modes only)
//   up_db_n, down_db_n       : debounced up/down levels, active-low
//   blink                    : display blink phase for the field being set
// master drives the buttons (board / bench side); slave is the controller.
interface clock_ctrl_if;
  logic       mode_btn_n;
  logic       up_n;
  logic       down_n;
  logic [1:0] mode;
  logic       sec_en;
  logic       en_5hz;
  logic       up_db_n;
  logic       down_db_n;
  logic       blink;

  modport master (
    output mode_btn_n, up_n, down_n,
    input  mode, sec_en, en_5hz, up_db_n, down_db_n, blink
  );

  modport slave (
    input  mode_btn_n, up_n, down_n,
    output mode, sec_en, en_5hz, up_db_n, down_db_n, blink
  );
endinterface

// File: rtl/clock_ctrl.sv
// clock_ctrl: control and sequencing for the digital clock's sec/min/hour counter.
// Synchronises and debounces the three buttons, runs the RUN/SET_SEC/SET_MIN/SET_HOUR
// mode machine with an inactivity timeout, and produces the 1 Hz count enable, the
// auto-repeat setting enable and the display blink phase. Every output is a flop.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   ctrl : clock_ctrl_if.slave (buttons in, mode/enables/debounced levels/blink out)
module clock_ctrl #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned REPEAT_HZ    = 5,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned TIMEOUT_S    = 10
) (
  input  logic        clk,
  input  logic        rst,
  clock_ctrl_if.slave ctrl
);

  localparam int unsigned RP = CLK_HZ / REPEAT_HZ;
  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned RW = (RP > 1) ? $clog2(RP) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned TW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;

  localparam logic [PW-1:0] PrescMax  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PrescHalf = PW'(CLK_HZ / 2);
  localparam logic [RW-1:0] RepMax    = RW'(RP - 1);
  localparam logic [DW-1:0] DbMax     = DW'(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0] ToMax     = TW'(TIMEOUT_S - 1);

  // Bit positions in the per-button vectors.
  localparam int unsigned BtnMode = 0;
  localparam int unsigned BtnUp   = 1;
  localparam int unsigned BtnDown = 2;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StSetSec  = 2'b01,
    StSetMin  = 2'b10,
    StSetHour = 2'b11
  } mode_e;

  // Button conditioning
  logic [2:0]         btn_raw;
  logic [2:0]         sync1_q, sync2_q;
  logic [2:0]         acc_q, acc_d;
  logic [2:0][DW-1:0] db_cnt_q, db_cnt_d;
  logic [2:0]         press_q, press_d;

  // Control
  mode_e         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          sec_en_q, sec_en_d;
  logic          en_5hz_q, en_5hz_d;
  logic          blink_q, blink_d;

  logic sec_tick;
  logic timeout;
  logic mode_chg;
  logic held;
  logic ud_press;

  assign btn_raw = {ctrl.down_n, ctrl.up_n, ctrl.mode_btn_n};

  // Debounce: the accepted level only moves after DEBOUNCE_CYC consecutive cycles of
  // disagreement; any agreement in between restarts the count.
  always_comb begin
    acc_d    = acc_q;
    db_cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != acc_q[i]) begin
        if (db_cnt_q[i] == DbMax) begin
          acc_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Press event: accepted level falling, registered into a one-cycle pulse.
  assign press_d = acc_q & ~acc_d;

  assign held     = ~acc_q[BtnUp] | ~acc_q[BtnDown];
  assign ud_press = press_q[BtnUp] | press_q[BtnDown];
  assign sec_tick = (presc_q == PrescMax);
  assign timeout  = (mode_q != StRun) && sec_tick && (to_cnt_q == ToMax);

  // Mode machine, prescaler, timeout, auto-repeat and registered outputs.
  always_comb begin
    mode_d   = mode_q;
    presc_d  = presc_q + 1'b1;
    to_cnt_d = to_cnt_q;
    rep_d    = '0;
    en_5hz_d = 1'b0;
    sec_en_d = sec_tick && (mode_q == StRun);

    if (press_q[BtnMode]) begin
      unique case (mode_q)
        StRun:     mode_d = StSetSec;
        StSetSec:  mode_d = StSetMin;
        StSetMin:  mode_d = StSetHour;
        StSetHour: mode_d = StRun;
      endcase
    end else if (timeout) begin
      mode_d = StRun;
    end

    mode_chg = (mode_d != mode_q);

    // Returning to RUN restarts the second so the first count lands a full second later.
    if (sec_tick || (mode_chg && (mode_d == StRun))) begin
      presc_d = '0;
    end

    // Any setting step or mode change counts as activity.
    if (mode_chg || (mode_q == StRun) || en_5hz_q) begin
      to_cnt_d = '0;
    end else if (sec_tick) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    // A mode change swallows a coincident up/down press; a still-held button then
    // repeats in the new mode only after a full repeat period.
    if ((mode_q != StRun) && !mode_chg) begin
      if (ud_press) begin
        en_5hz_d = 1'b1;
      end else if (held) begin
        if (rep_q == RepMax) begin
          en_5hz_d = 1'b1;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
    end

    // Computed from next state so blink stays aligned with mode and prescaler.
    blink_d = (mode_d != StRun) && (presc_d < PrescHalf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      acc_q    <= '1;
      db_cnt_q <= '0;
      press_q  <= '0;
      mode_q   <= StRun;
      presc_q  <= '0;
      to_cnt_q <= '0;
      rep_q    <= '0;
      sec_en_q <= 1'b0;
      en_5hz_q <= 1'b0;
      blink_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      acc_q    <= acc_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
      mode_q   <= mode_d;
      presc_q  <= presc_d;
      to_cnt_q <= to_cnt_d;
      rep_q    <= rep_d;
      sec_en_q <= sec_en_d;
      en_5hz_q <= en_5hz_d;
      blink_q  <= blink_d;
    end
  end

  assign ctrl.mode      = mode_q;
  assign ctrl.sec_en    = sec_en_q;
  assign ctrl.en_5hz    = en_5hz_q;
  assign ctrl.up_db_n   = acc_q[BtnUp];
  assign ctrl.down_db_n = acc_q[BtnDown];
  assign ctrl.blink     = blink_q;

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
- Control and sequencing block for the digital clock's timekeeping counter (second/minute/hour datapath).
- Conditions the three active-low push-buttons (mode, up, down): synchronise, then debounce.
- Runs the mode state machine (RUN / SET_SEC / SET_MIN / SET_HOUR) with an inactivity timeout.
- Generates the 1 Hz count enable and the 5 Hz auto-repeat setting enable, plus a display blink flag. All drive the counter and display directly.

Parameters:
- CLK_HZ, 50_000_000: input clock frequency in Hz; length of the 1 s prescaler.
- REPEAT_HZ, 5: auto-repeat rate while up/down is held. Repeat period RP = CLK_HZ/REPEAT_HZ cycles, integer division.
- DEBOUNCE_CYC, 1_000_000: consecutive stable cycles required to accept a button level (20 ms at 50 MHz).
- TIMEOUT_S, 10: seconds without up/down activity before a set mode falls back to RUN.

Ports:
- clk  in  1  system clock, 50 MHz on the DE2 board.
- rst  in  1  reset; asynchronous assert, active-high.
- mode_btn_n  in  1  raw mode button, active-low, asynchronous to clk.
- up_n  in  1  raw up button, active-low, asynchronous.
- down_n  in  1  raw down button, active-low, asynchronous.
- mode  out  2  00 RUN, 01 SET_SEC, 10 SET_MIN, 11 SET_HOUR.
- sec_en  out  1  one-cycle pulse once per second; RUN only.
- en_5hz  out  1  one-cycle setting-step pulse; set modes only.
- up_db_n  out  1  debounced up level, active-low.
- down_db_n  out  1  debounced down level, active-low.
- blink  out  1  display blink phase for the field being set; 0 in RUN.

Behaviour:
- Reset (async, rst=1): mode=00; sec_en=0; en_5hz=0; blink=0; up_db_n=1; down_db_n=1; debounced mode level=1; all counters=0. First edge after release operates normally.
- Synchroniser: 2-FF per button. Synchronised level reaches the debouncer 2 cycles after the pin changes.
- Debouncer, per button:
  - Counter clears whenever the synchronised level equals the accepted level.
  - Otherwise it increments; on reaching DEBOUNCE_CYC-1 the accepted level updates and the counter clears.
  - A glitch shorter than DEBOUNCE_CYC cycles is never accepted.
- Press event: accepted level 1->0, registered, one-cycle internal pulse.
- Prescaler (0..CLK_HZ-1, wraps): sec_tick = count==CLK_HZ-1. sec_en = sec_tick AND mode==00, registered, 1 cycle wide.
  - Prescaler clears on the cycle mode returns to RUN, so the first sec_en occurs CLK_HZ cycles after return.
- Mode FSM, on a mode press: RUN->SET_SEC->SET_MIN->SET_HOUR->RUN.
  - Timeout counter counts sec_ticks while in a set mode.
  - It clears on any mode transition and on every en_5hz pulse.
  - At TIMEOUT_S it forces RUN (timeout counts as a mode transition).
- Auto-repeat, set modes only, while up_db_n=0 or down_db_n=0:
  - An up or down press event gives en_5hz=1 on the next cycle and restarts the repeat counter at 0.
  - While either button stays held, en_5hz pulses each time the repeat counter hits RP-1; the counter wraps to 0.
  - Both buttons released: counter held at 0, no pulses.
  - Both held: pulses continue; the datapath gives up priority.
  - In RUN, en_5hz=0 and the repeat counter is held at 0.
- Simultaneous mode press and up/down event in the same cycle: mode change wins. en_5hz is suppressed that cycle and the repeat counter clears. A button still held then starts repeating in the new mode after RP cycles; no immediate pulse.
- blink: in set modes, 1 while prescaler < CLK_HZ/2, else 0. Forced 0 in RUN.
- Latencies:
  - pin change to accepted level: 2 + DEBOUNCE_CYC cycles
  - accepted press to en_5hz or mode update: 1 cycle
- All outputs registered. No combinational path from any input to any output.
- rst asserted mid-setting: immediate RUN and all outputs at reset values. No en_5hz or sec_en pulse is emitted after rst asserts.

Test Plan (bench params CLK_HZ=20, REPEAT_HZ=5 so RP=4, DEBOUNCE_CYC=3, TIMEOUT_S=2):
- Reset, all buttons high, run 100 cycles -> mode=00; sec_en pulses every 20 cycles, 5 total; en_5hz=0; blink=0.
- 2-cycle low glitch on mode_btn_n -> mode stays 00. Clean 10-cycle press -> mode=01 exactly 2+3+1 cycles after the falling pin edge. Three more clean presses -> 10, 11, 00 in sequence.
- In mode 01, hold up_n low 12 cycles after acceptance -> en_5hz on the cycle after acceptance, then every 4 cycles (4 pulses total); sec_en never asserts; up_db_n=0 throughout the hold.
- In mode 10, no up/down activity -> mode=00 on the 2nd sec_tick after entry. Prescaler cleared on the return, next sec_en 20 cycles later.
- down held with mode press accepted in the same cycle as the down press -> mode advances; no en_5hz that cycle; next en_5hz 4 cycles later.
- rst pulsed for 1 cycle while in mode 11 with up held -> mode=00, en_5hz=0, up_db_n=1 immediately. up_db_n re-accepts 0 after 2+3 cycles; no en_5hz since mode is RUN.
